// File: rtl/w0rm_gpio_bank_if.sv
// Single-cycle CPU bus used to reach the W0RM GPIO bank registers.
// master = CPU side, slave = peripheral side.
interface w0rm_gpio_bank_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic                  mem_valid;
    logic                  mem_write;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data_in;
    logic [DATA_WIDTH-1:0] mem_data_out;
    logic                  mem_data_valid;

    modport master (
        output mem_valid, mem_write, mem_addr, mem_data_in,
        input  mem_data_out, mem_data_valid
    );

    modport slave (
        input  mem_valid, mem_write, mem_addr, mem_data_in,
        output mem_data_out, mem_data_valid
    );
endinterface

// File: rtl/w0rm_gpio_bank.sv
// Parametrised GPIO bank: per-port data/direction registers, synchronised and
// debounced inputs, and W1C edge interrupts behind a single-cycle register bus.
module w0rm_gpio_bank #(
    parameter int NUM_PORTS       = 3,
    parameter int PORT_WIDTH      = 8,
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 8,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    w0rm_gpio_bank_if.slave                 bus,
    input  logic [NUM_PORTS*PORT_WIDTH-1:0] gpio_in,
    output logic [NUM_PORTS*PORT_WIDTH-1:0] gpio_out,
    output logic [NUM_PORTS*PORT_WIDTH-1:0] gpio_oe,
    output logic                            irq
);

    localparam int PAW = ADDR_WIDTH - 3;
    localparam int CW  = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] D_CNT = CW'(DEBOUNCE_CYCLES);

    logic [PORT_WIDTH-1:0] r_data_out   [NUM_PORTS];
    logic [PORT_WIDTH-1:0] r_dir        [NUM_PORTS];
    logic [PORT_WIDTH-1:0] r_irq_en     [NUM_PORTS];
    logic [PORT_WIDTH-1:0] r_irq_status [NUM_PORTS];
    logic [PORT_WIDTH-1:0] r_edge_sel   [NUM_PORTS];
    logic [PORT_WIDTH-1:0] r_sync1      [NUM_PORTS];
    logic [PORT_WIDTH-1:0] r_sync2      [NUM_PORTS];
    logic [PORT_WIDTH-1:0] r_prev       [NUM_PORTS];
    logic [PORT_WIDTH-1:0] r_stable     [NUM_PORTS];
    logic [CW-1:0]         r_cnt        [NUM_PORTS];

    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_rvalid;
    logic                  r_irq;

    logic [PAW-1:0]        w_port;
    logic [2:0]            w_reg;
    logic                  w_wr;
    logic                  w_rd;
    logic [PORT_WIDTH-1:0] w_wdata;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic                  w_irq_nxt;
    logic                  w_sel        [NUM_PORTS];
    logic [CW-1:0]         w_cnt_nxt    [NUM_PORTS];
    logic [PORT_WIDTH-1:0] w_stable_nxt [NUM_PORTS];
    logic [PORT_WIDTH-1:0] w_edge       [NUM_PORTS];
    logic [PORT_WIDTH-1:0] w_clr        [NUM_PORTS];

    assign w_port  = bus.mem_addr[ADDR_WIDTH-1:3];
    assign w_reg   = bus.mem_addr[2:0];
    assign w_wr    = bus.mem_valid & bus.mem_write;
    assign w_rd    = bus.mem_valid & ~bus.mem_write;
    assign w_wdata = bus.mem_data_in[PORT_WIDTH-1:0];

    assign bus.mem_data_out   = r_rdata;
    assign bus.mem_data_valid = r_rvalid;
    assign irq                = r_irq;

    // Debounce, edge detect and W1C decode per port; ports beyond NUM_PORTS never select.
    always_comb begin
        w_irq_nxt = 1'b0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            w_sel[p] = (w_port == PAW'(p));
            if (r_sync2[p] != r_prev[p])
                w_cnt_nxt[p] = '0;
            else if (r_cnt[p] == D_CNT)
                w_cnt_nxt[p] = D_CNT;
            else
                w_cnt_nxt[p] = r_cnt[p] + 1'b1;
            w_stable_nxt[p] = (w_cnt_nxt[p] == D_CNT) ? r_sync2[p] : r_stable[p];
            w_edge[p] = (~r_stable[p] &  w_stable_nxt[p] & ~r_edge_sel[p]) |
                        ( r_stable[p] & ~w_stable_nxt[p] &  r_edge_sel[p]);
            w_clr[p]  = (w_wr && w_sel[p] && w_reg == 3'd4) ? w_wdata : '0;
            w_irq_nxt = w_irq_nxt | (|(r_irq_status[p] & r_irq_en[p]));
        end
    end

    always_comb begin
        w_rdata = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (w_sel[p]) begin
                case (w_reg)
                    3'd0:    w_rdata = DATA_WIDTH'(r_data_out[p]);
                    3'd1:    w_rdata = DATA_WIDTH'(r_dir[p]);
                    3'd2:    w_rdata = DATA_WIDTH'(r_stable[p]);
                    3'd3:    w_rdata = DATA_WIDTH'(r_irq_en[p]);
                    3'd4:    w_rdata = DATA_WIDTH'(r_irq_status[p]);
                    3'd5:    w_rdata = DATA_WIDTH'(r_edge_sel[p]);
                    default: w_rdata = '0;
                endcase
            end
        end
    end

    always_comb begin
        gpio_out = '0;
        gpio_oe  = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            gpio_out[p*PORT_WIDTH +: PORT_WIDTH] = r_data_out[p];
            gpio_oe[p*PORT_WIDTH +: PORT_WIDTH]  = r_dir[p];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
            r_irq    <= 1'b0;
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                r_data_out[p]   <= '0;
                r_dir[p]        <= '0;
                r_irq_en[p]     <= '0;
                r_irq_status[p] <= '0;
                r_edge_sel[p]   <= '0;
                r_sync1[p]      <= '0;
                r_sync2[p]      <= '0;
                r_prev[p]       <= '0;
                r_stable[p]     <= '0;
                r_cnt[p]        <= '0;
            end
        end else begin
            r_rvalid <= w_rd;
            if (w_rd)
                r_rdata <= w_rdata;
            r_irq <= w_irq_nxt;
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                r_sync1[p]  <= gpio_in[p*PORT_WIDTH +: PORT_WIDTH];
                r_sync2[p]  <= r_sync1[p];
                r_prev[p]   <= r_sync2[p];
                r_cnt[p]    <= w_cnt_nxt[p];
                r_stable[p] <= w_stable_nxt[p];
                // A fresh edge overrides a simultaneous clear of the same bit.
                r_irq_status[p] <= (r_irq_status[p] & ~w_clr[p]) | w_edge[p];
                if (w_wr && w_sel[p]) begin
                    case (w_reg)
                        3'd0:    r_data_out[p] <= w_wdata;
                        3'd1:    r_dir[p]      <= w_wdata;
                        3'd3:    r_irq_en[p]   <= w_wdata;
                        3'd5:    r_edge_sel[p] <= w_wdata;
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_w0rm_gpio_bank.sv
// Self-checking bench for w0rm_gpio_bank: register table plus debounce,
// interrupt, collision and reset sequences; read data checked via a scoreboard.
module tb_w0rm_gpio_bank;

    localparam int NP = 3;
    localparam int PW = 8;
    localparam int DW = 32;
    localparam int AW = 8;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [NP*PW-1:0] gpio_in = '0;
    logic [NP*PW-1:0] gpio_out;
    logic [NP*PW-1:0] gpio_oe;
    logic            irq;

    w0rm_gpio_bank_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_if ();

    w0rm_gpio_bank #(
        .NUM_PORTS(NP), .PORT_WIDTH(PW), .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW), .DEBOUNCE_CYCLES(16)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus_if.slave),
        .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } rd_exp_t;

    typedef struct {
        string       name;
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    rd_exp_t sb[$];
    vec_t    vecs[$];
    int      n_tests = 0;
    int      n_fail  = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Scoreboard: every read-data pulse must match the oldest outstanding read.
    always @(negedge clk) begin
        if (!reset && bus_if.mem_data_valid) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_rvalid: got data 0x%08h with no read pending", bus_if.mem_data_out);
            end else begin
                rd_exp_t e;
                e = sb.pop_front();
                check(e.name, bus_if.mem_data_out, e.exp);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        bus_if.mem_valid   = 1'b1;
        bus_if.mem_write   = 1'b1;
        bus_if.mem_addr    = a;
        bus_if.mem_data_in = d;
        tick(1);
        bus_if.mem_valid = 1'b0;
        bus_if.mem_write = 1'b0;
    endtask

    task automatic bus_read(input string nm, input logic [7:0] a, input logic [31:0] exp);
        rd_exp_t e;
        e.name = nm;
        e.exp  = exp;
        sb.push_back(e);
        bus_if.mem_valid = 1'b1;
        bus_if.mem_write = 1'b0;
        bus_if.mem_addr  = a;
        tick(1);
        bus_if.mem_valid = 1'b0;
    endtask

    task automatic add(input string nm, input bit wr, input logic [7:0] a,
                       input logic [31:0] d, input logic [31:0] exp);
        vec_t v;
        v.name = nm; v.wr = wr; v.addr = a; v.data = d; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        check("rst_gpio_oe",  32'(gpio_oe),  32'h0);
        check("rst_gpio_out", 32'(gpio_out), 32'h0);
        check("rst_irq",      32'(irq),      32'h0);
    endtask

    initial begin
        bus_if.mem_valid   = 1'b0;
        bus_if.mem_write   = 1'b0;
        bus_if.mem_addr    = '0;
        bus_if.mem_data_in = '0;

        add("rst_p0_dout",   0, 8'h00, 32'h0,        32'h0);
        add("rst_p1_stat",   0, 8'h0C, 32'h0,        32'h0);
        add("rst_p2_esel",   0, 8'h15, 32'h0,        32'h0);
        add("",              1, 8'h09, 32'h000000FF, 32'h0);
        add("",              1, 8'h08, 32'h123456A5, 32'h0);
        add("p1_dout_rb",    0, 8'h08, 32'h0,        32'h000000A5);
        add("p1_dir_rb",     0, 8'h09, 32'h0,        32'h000000FF);
        add("",              1, 8'h10, 32'h0000003C, 32'h0);
        add("p2_dout_rb",    0, 8'h10, 32'h0,        32'h0000003C);
        add("",              1, 8'h15, 32'h0000000F, 32'h0);
        add("p2_esel_rb",    0, 8'h15, 32'h0,        32'h0000000F);
        add("",              1, 8'h18, 32'hFFFFFFFF, 32'h0);
        add("p3_unmapped",   0, 8'h18, 32'h0,        32'h0);
        add("",              1, 8'h0E, 32'hFFFFFFFF, 32'h0);
        add("p1_off6",       0, 8'h0E, 32'h0,        32'h0);
        add("p1_off7",       0, 8'h0F, 32'h0,        32'h0);
        add("p1_din_idle",   0, 8'h0A, 32'h0,        32'h0);
        add("",              1, 8'h11, 32'h00000001, 32'h0);
        add("p2_dir_rb",     0, 8'h11, 32'h0,        32'h00000001);

        do_reset();
        foreach (vecs[i]) begin
            if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].data);
            else            bus_read(vecs[i].name, vecs[i].addr, vecs[i].exp);
        end
        tick(1);
        check("gpio_oe_map",  32'(gpio_oe),  32'h0001FF00);
        check("gpio_out_map", 32'(gpio_out), 32'h003CA500);
        check("irq_idle",     32'(irq),      32'h0);

        // Input on a port driven as output still reads back through DATA_IN.
        gpio_in[15:8] = 8'h5A;
        tick(25);
        bus_read("p1_din_dirout", 8'h0A, 32'h5A);
        bus_read("p1_stat_rise",  8'h0C, 32'h5A);
        check("irq_masked", 32'(irq), 32'h0);

        // Glitch shorter than the debounce window is rejected.
        bus_write(8'h03, 32'h80);
        gpio_in[7] = 1'b1;
        tick(10);
        gpio_in[7] = 1'b0;
        tick(30);
        bus_read("db_glitch_din",  8'h02, 32'h0);
        bus_read("db_glitch_stat", 8'h04, 32'h0);
        check("db_glitch_irq", 32'(irq), 32'h0);

        // Clean rise lands in DATA_IN exactly 19 cycles after reaching the pad.
        gpio_in[7] = 1'b1;
        tick(18);
        bus_read("db_edge_early", 8'h02, 32'h0);
        check("irq_before_edge", 32'(irq), 32'h0);
        bus_read("db_edge_on", 8'h02, 32'h80);
        check("irq_rise", 32'(irq), 32'h1);
        bus_read("stat_rise", 8'h04, 32'h80);
        bus_write(8'h04, 32'h80);
        check("irq_w1c_lag", 32'(irq), 32'h1);
        tick(1);
        check("irq_w1c_clr", 32'(irq), 32'h0);
        bus_read("stat_w1c", 8'h04, 32'h0);

        // Falling edge select; changing EDGE_SEL alone must not set status.
        bus_write(8'h05, 32'h80);
        bus_read("esel_no_edge", 8'h04, 32'h0);
        gpio_in[7] = 1'b0;
        tick(25);
        bus_read("stat_fall", 8'h04, 32'h80);
        bus_write(8'h04, 32'h80);
        tick(2);
        check("irq_fall_clr", 32'(irq), 32'h0);

        // Clear and new edge on bit 0 in the same cycle: edge wins.
        bus_write(8'h03, 32'h01);
        gpio_in[0] = 1'b1;
        tick(25);
        check("irq_bit0_first", 32'(irq), 32'h1);
        gpio_in[0] = 1'b0;
        tick(25);
        bus_read("stat_bit0_held", 8'h04, 32'h01);
        gpio_in[0] = 1'b1;
        tick(18);
        bus_write(8'h04, 32'h01);
        check("irq_collide_a", 32'(irq), 32'h1);
        tick(1);
        check("irq_collide_b", 32'(irq), 32'h1);
        bus_read("stat_collide", 8'h04, 32'h01);
        bus_read("din_collide",  8'h02, 32'h01);
        bus_write(8'h04, 32'h01);
        tick(2);
        check("irq_after_clr", 32'(irq), 32'h0);
        bus_read("stat_after_clr", 8'h04, 32'h0);

        // Reset in the middle of a debounce discards the pending value.
        gpio_in[1] = 1'b1;
        tick(5);
        do_reset();
        bus_read("rst_mid_din",  8'h02, 32'h0);
        bus_read("rst_mid_dout", 8'h08, 32'h0);
        bus_read("rst_mid_ien",  8'h03, 32'h0);
        tick(25);
        bus_read("din_after_rst", 8'h02, 32'h03);

        tick(3);
        check("sb_drained", 32'(sb.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/w0rm_gpio_bank.md
Name: w0rm_gpio_bank

Overview:
Parametrised multi-port GPIO peripheral for the W0RM demo SoC. It replaces the fixed 8-bit switch/LED/mode ports with NUM_PORTS ports of PORT_WIDTH bits. Each port has per-bit direction control, an input synchroniser, a debouncer, and edge-detect interrupts. The CPU reaches all registers through a simple single-cycle memory-mapped bus.

Parameters:
NUM_PORTS, 3, number of GPIO ports (1..8)
PORT_WIDTH, 8, bits per port (1..DATA_WIDTH)
DATA_WIDTH, 32, CPU bus data width
ADDR_WIDTH, 8, CPU bus byte-independent word address width (must hold NUM_PORTS*8)
DEBOUNCE_CYCLES, 16, clocks an input must be stable before acceptance; 0 = bypass

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
mem_valid  in  1  bus request strobe
mem_write  in  1  1 = write, 0 = read
mem_addr  in  ADDR_WIDTH  word address = port*8 + reg
mem_data_in  in  DATA_WIDTH  write data
mem_data_out  out  DATA_WIDTH  read data
mem_data_valid  out  1  read data valid pulse
gpio_in  in  NUM_PORTS*PORT_WIDTH  pad inputs, port p at bits [p*PORT_WIDTH +: PORT_WIDTH]
gpio_out  out  NUM_PORTS*PORT_WIDTH  pad output values
gpio_oe  out  NUM_PORTS*PORT_WIDTH  pad output enables, 1 = drive
irq  out  1  level interrupt to CPU

Behaviour:
- Reset (async, active-high): all registers 0. gpio_out=0, gpio_oe=0 (all inputs), irq=0, mem_data_out=0, mem_data_valid=0. Sync, stable and debounce state clear to 0.
- Register map per port (reg offset):
  - 0 DATA_OUT: RW.
  - 1 DIR: RW, 1 = output.
  - 2 DATA_IN: RO, debounced value.
  - 3 IRQ_EN: RW.
  - 4 IRQ_STATUS: W1C.
  - 5 EDGE_SEL: RW, 0 = rising, 1 = falling.
  - Offsets 6-7 and ports >= NUM_PORTS read 0; writes to them are ignored.
- Bus:
  - Every cycle with mem_valid=1 is accepted; there is no stall.
  - Writes take effect on the next clock edge.
  - Reads: mem_data_valid=1 and mem_data_out=data exactly one cycle after the request. When no read occurs, mem_data_valid=0 and mem_data_out holds its last value.
  - Bits above PORT_WIDTH: written bits are ignored, read bits are 0.
- gpio_out = DATA_OUT and gpio_oe = DIR, both registered directly with no extra delay.
- Input path per bit: 2-flop synchroniser, then debouncer.
  - Each port has one counter. It resets to 0 when the synchronised vector differs from its previous-cycle value, otherwise it increments, saturating at DEBOUNCE_CYCLES.
  - When the counter reaches DEBOUNCE_CYCLES, stable <= synchronised vector.
  - A clean change appears in DATA_IN 2 + DEBOUNCE_CYCLES + 1 cycles after it reaches gpio_in.
  - DEBOUNCE_CYCLES=0: stable <= synchronised value every cycle.
- DATA_IN reflects the pad regardless of DIR.
- Edge detect runs on the stable value:
  - rise = ~old & new; fall = old & ~new.
  - Selected edges OR into IRQ_STATUS whatever IRQ_EN is; status is always recorded.
- IRQ_STATUS W1C: a written 1 clears the bit. If a clear and a new edge on the same bit fall in the same cycle, the edge wins and the bit stays set.
- irq = registered OR over all ports of (IRQ_STATUS & IRQ_EN). It appears one cycle after status or enable changes.
- Changing EDGE_SEL does not create an edge. Reset mid-debounce discards the pending value.

Test Plan:
- Reset: assert reset for 3 cycles -> gpio_oe=0, gpio_out=0, irq=0. Read any register -> 0 on the next cycle with mem_data_valid=1.
- Output: write DIR port1 = 0xFF, DATA_OUT port1 = 0xA5 -> gpio_oe[15:8]=0xFF, gpio_out[15:8]=0xA5. Readback of port1 reg 0 returns 0x000000A5.
- Debounce (DEBOUNCE_CYCLES=16): apply gpio_in[7]=1 for 10 cycles, then 0 -> DATA_IN port0 stays 0x00. Hold it at 1 -> DATA_IN reads 0x80 after 19 cycles.
- Interrupt: IRQ_EN port0 = 0x80, EDGE_SEL = 0, clean rise on bit 7 -> IRQ_STATUS=0x80 and irq=1. Write 0x80 to IRQ_STATUS -> status 0, irq=0 one cycle later.
- Clear/edge collision: time a W1C of bit 0 in the same cycle that bit 0's stable value rises -> status bit remains 1 and irq stays 1.
- Unmapped: write 0xFFFFFFFF to port 3 (NUM_PORTS=3) and to offset 6 -> all outputs unchanged, reads return 0.
